dmp_iteration_scheduler: RTL and testbench

//  Deterministic iteration controller for the PageRank gather/serialize path.

---
 rtl/dmp_iteration_scheduler.sv | 145 ++++++++++++++
 tb/tb_dmp_iteration_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmp_iteration_scheduler.sv
// dmp_iteration_scheduler
//   Iteration controller for the PageRank gather/serialize path. Waits for
//   every gather thread to report completion, streams the per-thread vectors
//   out in fixed order 0..N-1 under consumer backpressure, pulses
//   next_iteration, and repeats until the programmed iteration count is hit.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no run active, all outputs low
//   BARRIER  | collecting sticky thread_done bits until all are set
//   SEND     | presenting beat thread_sel on the output stream
//   ADVANCE  | one-cycle next_iteration pulse, iteration counted
//   FINISHED | run complete, run_done held until start/abort/reset
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   start, num_iters  launch a run of num_iters iterations (IDLE/FINISHED only)
//   abort             return to IDLE, drop any in-flight beat
//   thread_done       per-thread gather complete, only observed in BARRIER
//   out_ready         consumer accepts the current beat
//   out_valid, thread_sel, stream_start, stream_end   stream beat signals
//   next_iteration    one-cycle pulse releasing the next gather
//   iter_count        completed iterations in this run
//   busy, run_done    run status
module dmp_iteration_scheduler #(
  parameter int NUM_HW_THREADS = 8,
  parameter int TID_W          = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1,
  parameter int ITER_W         = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ITER_W-1:0]         num_iters,
  input  logic [NUM_HW_THREADS-1:0] thread_done,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [TID_W-1:0]          thread_sel,
  output logic                      stream_start,
  output logic                      stream_end,
  output logic                      next_iteration,
  output logic [ITER_W-1:0]         iter_count,
  output logic                      busy,
  output logic                      run_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BARRIER  = 3'd1,
    SEND     = 3'd2,
    ADVANCE  = 3'd3,
    FINISHED = 3'd4
  } state_t;

  localparam logic [TID_W-1:0]          LAST_SEL = TID_W'(NUM_HW_THREADS - 1);
  localparam logic [NUM_HW_THREADS-1:0] ALL_DONE = {NUM_HW_THREADS{1'b1}};

  state_t                      state;
  logic [NUM_HW_THREADS-1:0]   done_latched;
  logic [ITER_W-1:0]           iter_limit;

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      state          <= IDLE;
      done_latched   <= '0;
      iter_limit     <= '0;
      thread_sel     <= '0;
      iter_count     <= '0;
      out_valid      <= 1'b0;
      stream_start   <= 1'b0;
      stream_end     <= 1'b0;
      next_iteration <= 1'b0;
      busy           <= 1'b0;
      run_done       <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISHED: begin
          if (start) begin
            iter_count   <= '0;
            done_latched <= '0;
            thread_sel   <= '0;
            if (num_iters == '0) begin
              state    <= FINISHED;
              run_done <= 1'b1;
              busy     <= 1'b0;
            end else begin
              iter_limit <= num_iters;
              run_done   <= 1'b0;
              busy       <= 1'b1;
              state      <= BARRIER;
            end
          end
        end

        BARRIER: begin
          done_latched <= done_latched | thread_done;
          // Exit is decided on the registered vector, so the stream starts
          // one cycle after the final completion bit is captured.
          if (done_latched == ALL_DONE) begin
            state        <= SEND;
            thread_sel   <= '0;
            out_valid    <= 1'b1;
            stream_start <= 1'b1;
            stream_end   <= (LAST_SEL == '0);
          end
        end

        SEND: begin
          if (out_ready) begin
            if (thread_sel == LAST_SEL) begin
              state          <= ADVANCE;
              out_valid      <= 1'b0;
              stream_start   <= 1'b0;
              stream_end     <= 1'b0;
              thread_sel     <= '0;
              done_latched   <= '0;
              next_iteration <= 1'b1;
              if (iter_count != iter_limit) begin
                iter_count <= iter_count + ITER_W'(1);
              end
            end else begin
              thread_sel   <= thread_sel + TID_W'(1);
              stream_start <= 1'b0;
              stream_end   <= ((thread_sel + TID_W'(1)) == LAST_SEL);
            end
          end
        end

        ADVANCE: begin
          next_iteration <= 1'b0;
          if (iter_count == iter_limit) begin
            state    <= FINISHED;
            run_done <= 1'b1;
            busy     <= 1'b0;
          end else begin
            state <= BARRIER;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmp_iteration_scheduler.sv
module tb_dmp_iteration_scheduler;

  localparam int N      = 8;
  localparam int TID_W  = 3;
  localparam int ITER_W = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ITER_W-1:0] num_iters;
  logic [N-1:0]      thread_done;
  logic              out_ready;
  logic              out_valid;
  logic [TID_W-1:0]  thread_sel;
  logic              stream_start;
  logic              stream_end;
  logic              next_iteration;
  logic [ITER_W-1:0] iter_count;
  logic              busy;
  logic              run_done;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dmp_iteration_scheduler #(
    .NUM_HW_THREADS(N),
    .TID_W(TID_W),
    .ITER_W(ITER_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .abort(abort),
    .num_iters(num_iters),
    .thread_done(thread_done),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .thread_sel(thread_sel),
    .stream_start(stream_start),
    .stream_end(stream_end),
    .next_iteration(next_iteration),
    .iter_count(iter_count),
    .busy(busy),
    .run_done(run_done)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_sel"}, {29'd0, thread_sel}, 32'd0);
    check({tag, "_sstart"}, {31'd0, stream_start}, 32'd0);
    check({tag, "_send"}, {31'd0, stream_end}, 32'd0);
    check({tag, "_next"}, {31'd0, next_iteration}, 32'd0);
    check({tag, "_iter"}, {16'd0, iter_count}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, run_done}, 32'd0);
  endtask

  // Launch a run and fill the barrier in one pulse; returns with out_valid high.
  task automatic launch_to_send(input logic [ITER_W-1:0] n);
    num_iters = n;
    start = 1'b1;
    step();
    start = 1'b0;
    thread_done = '1;
    step();
    thread_done = '0;
    step();
  endtask

  initial begin
    int order[9];
    int es;
    int pulses;
    int guard;
    logic [N-1:0] pat;

    reset = 1'b1; start = 1'b0; abort = 1'b0; num_iters = '0;
    thread_done = '0; out_ready = 1'b0;

    // Reset
    step();
    step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();
    check_idle_outputs("idle");

    // Barrier with out-of-order pulses, bit 3 repeated
    order = '{3, 0, 7, 5, 3, 1, 6, 2, 4};
    num_iters = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("bar_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      pat = '0;
      pat[order[i]] = 1'b1;
      thread_done = pat;
      step();
      thread_done = '0;
      check($sformatf("bar_wait%0d", i), {31'd0, out_valid}, 32'd0);
    end
    step();
    check("bar_rise", {31'd0, out_valid}, 32'd1);

    // Backpressure pattern 1,0,0,1,0,0,...
    es = 0;
    for (int c = 0; c < 40 && es < N; c++) begin
      out_ready = (c % 3 == 0);
      check($sformatf("bp_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_sel_c%0d", c), {29'd0, thread_sel}, es);
      check($sformatf("bp_ss_c%0d", c), {31'd0, stream_start}, (es == 0) ? 32'd1 : 32'd0);
      check($sformatf("bp_se_c%0d", c), {31'd0, stream_end}, (es == N - 1) ? 32'd1 : 32'd0);
      step();
      if (out_ready) es++;
    end
    out_ready = 1'b0;
    check("bp_beats", es, N);
    check("adv_valid", {31'd0, out_valid}, 32'd0);
    check("adv_next", {31'd0, next_iteration}, 32'd1);
    check("adv_iter", {16'd0, iter_count}, 32'd1);
    step();
    check("fin1_done", {31'd0, run_done}, 32'd1);
    check("fin1_busy", {31'd0, busy}, 32'd0);
    check("fin1_next", {31'd0, next_iteration}, 32'd0);

    // Three iterations, threads always done
    num_iters = 16'd3;
    thread_done = '1;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("it_done_cleared", {31'd0, run_done}, 32'd0);
    pulses = 0;
    guard = 0;
    while (!run_done && guard < 100) begin
      if (next_iteration) begin
        pulses++;
        check($sformatf("it_count_p%0d", pulses), {16'd0, iter_count}, pulses);
      end
      step();
      guard++;
    end
    check("it_timeout", (guard < 100) ? 32'd1 : 32'd0, 32'd1);
    check("it_pulses", pulses, 3);
    check("it_final", {16'd0, iter_count}, 32'd3);
    check("it_busy", {31'd0, busy}, 32'd0);
    check("it_run_done", {31'd0, run_done}, 32'd1);
    thread_done = '0;
    out_ready = 1'b0;

    // Abort from FINISHED clears run_done
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle_outputs("abort_fin");

    // num_iters = 0
    num_iters = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("zero_done", {31'd0, run_done}, 32'd1);
    check("zero_valid", {31'd0, out_valid}, 32'd0);
    check("zero_iter", {16'd0, iter_count}, 32'd0);
    check("zero_busy", {31'd0, busy}, 32'd0);
    step();
    check("zero_valid2", {31'd0, out_valid}, 32'd0);

    // thread_done held during SEND must not pre-fill the next barrier
    launch_to_send(16'd2);
    check("hold_valid", {31'd0, out_valid}, 32'd1);
    thread_done = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) step();
    check("hold_adv", {31'd0, next_iteration}, 32'd1);
    thread_done = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("hold_no_send", {31'd0, out_valid}, 32'd0);
    check("hold_busy", {31'd0, busy}, 32'd1);
    thread_done = '1;
    step();
    thread_done = '0;
    step();
    check("hold_send2", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) step();
    out_ready = 1'b0;
    step();
    check("hold_iter", {16'd0, iter_count}, 32'd2);
    check("hold_done", {31'd0, run_done}, 32'd1);

    // Abort at sel 4
    launch_to_send(16'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    check("ab_sel4", {29'd0, thread_sel}, 32'd4);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check_idle_outputs("ab");

    // Fresh full pass after abort
    launch_to_send(16'd1);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("re_sel%0d", i), {29'd0, thread_sel}, i);
      check($sformatf("re_valid%0d", i), {31'd0, out_valid}, 32'd1);
      step();
    end
    out_ready = 1'b0;
    check("re_next", {31'd0, next_iteration}, 32'd1);
    step();
    check("re_done", {31'd0, run_done}, 32'd1);
    check("re_iter", {16'd0, iter_count}, 32'd1);

    // Reset mid-SEND
    launch_to_send(16'd1);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    check("rs_sel2", {29'd0, thread_sel}, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_outputs("rs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
